alarm_set_panel: RTL and testbench

ALARM_SET_PANEL -- requirements
Module: alarm_set_panel

---
 rtl/alarm_panel_pkg.sv | 27 ++
 rtl/alarm_set_panel_btn_debounce.sv | 61 ++++++
 rtl/alarm_set_panel.sv | 169 ++++++++++++++++
 tb/tb_alarm_set_panel.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_panel_pkg.sv
// alarm_panel_pkg
// Shared definitions for the alarm-setting panel: edit-state enum, field
// widths, wrap limits and the wrap-around increment helpers.
package alarm_panel_pkg;

  localparam int HR_MAX  = 23;
  localparam int MIN_MAX = 59;
  localparam int HR_W    = 5;
  localparam int MIN_W   = 6;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } panel_state_t;

  // Hour +1 with 23 -> 0 wrap.
  function automatic logic [HR_W-1:0] next_hr(input logic [HR_W-1:0] hr);
    return (hr == HR_W'(HR_MAX)) ? '0 : hr + 1'b1;
  endfunction

  // Minute +1 with 59 -> 0 wrap.
  function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] mn);
    return (mn == MIN_W'(MIN_MAX)) ? '0 : mn + 1'b1;
  endfunction

endpackage

// File: rtl/alarm_set_panel_btn_debounce.sv
// btn_debounce
// Conditions one raw push-button: 2-flop synchronizer, counting debouncer
// and a one-cycle press pulse on the debounced rising edge.
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous active-high reset
//   btn    - raw asynchronous button input, 1 = pressed
//   level  - debounced button level
//   press  - one-cycle pulse, asserted in the same cycle level first reads 1
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]       sync_q;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  assign synced = sync_q[1];

  // Two-stage synchronizer; nothing downstream looks at the raw pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  // The counter only runs while the synchronized input disagrees with the
  // debounced level; any agreement restarts it. The press pulse is raised on
  // the same edge that flips the level high, so it needs no extra edge flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (synced != level) begin
        if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          cnt   <= '0;
          level <= synced;
          press <= synced;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alarm_set_panel.sv
// alarm_set_panel
// Two-button alarm time editor. Mode cycles RUN -> SET_HR -> SET_MIN -> RUN,
// inc bumps the field being edited. Edits live in shadow registers and are
// committed to alarm_hr/alarm_min only when leaving SET_MIN, so the alarm
// comparator never sees half-edited values.
// Optional feature: define BTN_AUTOREPEAT_EN to repeat increments every
// REPEAT_CYC cycles while inc is held in an edit state.
// Ports:
//   clk, rst      - clock (rising edge) and async active-high reset
//   btn_mode      - raw mode button
//   btn_inc       - raw increment button
//   alarm_hr      - committed alarm hour 0..23
//   alarm_min     - committed alarm minute 0..59
//   edit_hr       - high in SET_HR
//   edit_min      - high in SET_MIN
//   shadow_val    - value under edit, zero-extended, 0 in RUN
//   alarm_commit  - one-cycle pulse after a commit
module alarm_set_panel
  import alarm_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 2_000_000,
  parameter int REPEAT_CYC   = 20_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  output logic [HR_W-1:0]  alarm_hr,
  output logic [MIN_W-1:0] alarm_min,
  output logic             edit_hr,
  output logic             edit_min,
  output logic [MIN_W-1:0] shadow_val,
  output logic             alarm_commit
);

  panel_state_t     state, state_n;
  logic [HR_W-1:0]  shadow_hr, shadow_hr_n, alarm_hr_n;
  logic [MIN_W-1:0] shadow_min, shadow_min_n, alarm_min_n;
  logic             commit_n;

  logic mode_level, mode_press;
  logic inc_level, inc_press;
  logic inc_rep;
  logic inc_event;
  logic unused_mode_level;

  assign unused_mode_level = mode_level;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .level (mode_level),
    .press (mode_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_inc),
    .level (inc_level),
    .press (inc_press)
  );

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC + 1);

  logic [REP_W-1:0] rep_cnt;
  logic             editing;

  assign editing = (state != RUN);
  assign inc_rep = editing && inc_level && !inc_press &&
                   (rep_cnt == REP_W'(REPEAT_CYC - 1));

  // Repeat timer restarts on every press or repeat so repeats land at
  // press+REPEAT_CYC, +2*REPEAT_CYC, ...; release, RUN or a mode press
  // (state change) park it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if (!editing || !inc_level || inc_press || mode_press || inc_rep) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  localparam int unused_repeat_cyc = REPEAT_CYC;
  logic unused_inc_level;

  assign unused_inc_level = inc_level;
  assign inc_rep          = 1'b0;
`endif

  assign inc_event = inc_press | inc_rep;

  // Next-state/shadow computation. Mode has priority: an inc arriving in the
  // same cycle as a mode press is dropped.
  always_comb begin
    state_n      = state;
    shadow_hr_n  = shadow_hr;
    shadow_min_n = shadow_min;
    alarm_hr_n   = alarm_hr;
    alarm_min_n  = alarm_min;
    commit_n     = 1'b0;
    case (state)
      RUN: begin
        if (mode_press) begin
          state_n      = SET_HR;
          shadow_hr_n  = alarm_hr;
          shadow_min_n = alarm_min;
        end
      end
      SET_HR: begin
        if (mode_press) begin
          state_n = SET_MIN;
        end else if (inc_event) begin
          shadow_hr_n = next_hr(shadow_hr);
        end
      end
      SET_MIN: begin
        if (mode_press) begin
          state_n     = RUN;
          alarm_hr_n  = shadow_hr;
          alarm_min_n = shadow_min;
          commit_n    = 1'b1;
        end else if (inc_event) begin
          shadow_min_n = next_min(shadow_min);
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

  // All outputs are registered from the next-state values so they describe
  // the state/shadow that the edge just produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      shadow_hr    <= '0;
      shadow_min   <= '0;
      alarm_hr     <= '0;
      alarm_min    <= '0;
      alarm_commit <= 1'b0;
      edit_hr      <= 1'b0;
      edit_min     <= 1'b0;
      shadow_val   <= '0;
    end else begin
      state        <= state_n;
      shadow_hr    <= shadow_hr_n;
      shadow_min   <= shadow_min_n;
      alarm_hr     <= alarm_hr_n;
      alarm_min    <= alarm_min_n;
      alarm_commit <= commit_n;
      edit_hr      <= (state_n == SET_HR);
      edit_min     <= (state_n == SET_MIN);
      if (state_n == SET_HR) begin
        shadow_val <= MIN_W'(shadow_hr_n);
      end else if (state_n == SET_MIN) begin
        shadow_val <= shadow_min_n;
      end else begin
        shadow_val <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alarm_set_panel.sv
// tb_alarm_set_panel
// Scoreboard bench for alarm_set_panel (DEBOUNCE_CYC=4, REPEAT_CYC=10).
// Stimulus updates a time-of-day model and queues the expected visible
// panel state for every effective button event; a monitor pops an entry
// whenever the DUT's visible state changes and another on every commit pulse.
module tb_alarm_set_panel;

  localparam int DEB = 4;
  localparam int REP = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode;
  logic       btn_inc;
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic       edit_hr;
  logic       edit_min;
  logic [5:0] shadow_val;
  logic       alarm_commit;

  always #5 clk = ~clk;

  alarm_set_panel #(.DEBOUNCE_CYC(DEB), .REPEAT_CYC(REP)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .alarm_hr     (alarm_hr),
    .alarm_min    (alarm_min),
    .edit_hr      (edit_hr),
    .edit_min     (edit_min),
    .shadow_val   (shadow_val),
    .alarm_commit (alarm_commit)
  );

  typedef struct packed {
    logic       eh;
    logic       em;
    logic [5:0] sv;
    logic [4:0] ah;
    logic [5:0] am;
  } view_t;

  view_t       exp_q[$];
  logic [10:0] commit_q[$];
  int checks   = 0;
  int failures = 0;

  // Model: m_mode 0 = running, 1 = editing hour, 2 = editing minute.
  int m_mode, m_ah, m_am, m_sh, m_sm;

  function automatic view_t model_view();
    view_t v;
    v.eh = (m_mode == 1);
    v.em = (m_mode == 2);
    v.sv = (m_mode == 1) ? 6'(m_sh) : (m_mode == 2) ? 6'(m_sm) : 6'd0;
    v.ah = 5'(m_ah);
    v.am = 6'(m_am);
    return v;
  endfunction

  function automatic view_t dut_view();
    return {edit_hr, edit_min, shadow_val, alarm_hr, alarm_min};
  endfunction

  task automatic model_mode_press();
    if (m_mode == 0) begin
      m_sh = m_ah;
      m_sm = m_am;
      m_mode = 1;
    end else if (m_mode == 1) begin
      m_mode = 2;
    end else begin
      m_ah = m_sh;
      m_am = m_sm;
      m_mode = 0;
      commit_q.push_back({5'(m_ah), 6'(m_am)});
    end
    exp_q.push_back(model_view());
  endtask

  task automatic model_inc();
    if (m_mode == 0) return;
    if (m_mode == 1) m_sh = (m_sh + 1) % 24;
    else             m_sm = (m_sm + 1) % 60;
    exp_q.push_back(model_view());
  endtask

  task automatic model_reset();
    m_mode = 0; m_ah = 0; m_am = 0; m_sh = 0; m_sm = 0;
    exp_q.delete();
    commit_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 80 && (exp_q.size() != 0 || commit_q.size() != 0); i++) tick(1);
    checks++;
    if (exp_q.size() != 0 || commit_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s: pending views=%0d commits=%0d, required 0 and 0",
               name, exp_q.size(), commit_q.size());
      exp_q.delete();
      commit_q.delete();
    end
  endtask

  // Drive one press (clean or with a 1/0 bounce up front) held for `hold`
  // cycles, then release and let the DUT settle.
  task automatic applyStimulus(input bit do_mode, input bit do_inc,
                               input int hold, input bit bounce);
    int n;
    if (do_mode) begin
      model_mode_press();
    end else if (do_inc) begin
      n = 1;
`ifdef BTN_AUTOREPEAT_EN
      if (m_mode != 0) n += (hold - 1) / REP;
`endif
      repeat (n) model_inc();
    end
    if (bounce) begin
      btn_mode = do_mode; btn_inc = do_inc; tick(1);
      btn_mode = 1'b0;    btn_inc = 1'b0;   tick(1);
    end
    btn_mode = do_mode; btn_inc = do_inc;
    tick(hold);
    btn_mode = 1'b0; btn_inc = 1'b0;
    tick(DEB + 8);
    wait_drain("event_drain");
  endtask

  // Short pulse that must be rejected by the debouncer.
  task automatic applyGlitch(input bit on_mode, input int len);
    if (on_mode) btn_mode = 1'b1; else btn_inc = 1'b1;
    tick(len);
    btn_mode = 1'b0; btn_inc = 1'b0;
    tick(DEB + 8);
    wait_drain("glitch_drain");
  endtask

  task automatic checkOutput(input string name, input view_t expv, input logic exp_commit);
    view_t cur;
    @(negedge clk);
    cur = dut_view();
    checks++;
    if (cur !== expv || alarm_commit !== exp_commit) begin
      failures++;
      $display("[TB] FAIL %s: got view=%h commit=%b, required view=%h commit=%b",
               name, cur, alarm_commit, expv, exp_commit);
    end
    #1;
  endtask

  // Monitor: each change of the visible state consumes one queued view, each
  // commit pulse consumes one queued alarm value.
  view_t prev_view;
  logic  prev_commit;
  always @(negedge clk) begin
    view_t cur;
    view_t e;
    logic [10:0] c;
    cur = dut_view();
    if (rst) begin
      prev_view   = cur;
      prev_commit = 1'b0;
    end else begin
      if (cur !== prev_view) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_change: got view=%h, required no change from %h",
                   cur, prev_view);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            failures++;
            $display("[TB] FAIL view: got %h, required %h", cur, e);
          end
        end
      end
      if (alarm_commit === 1'b1) begin
        checks++;
        if (prev_commit) begin
          failures++;
          $display("[TB] FAIL commit_width: got commit high 2 cycles, required 1");
        end else if (commit_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected_commit: got alarm=%h, required no commit",
                   {alarm_hr, alarm_min});
        end else begin
          c = commit_q.pop_front();
          if ({alarm_hr, alarm_min} !== c) begin
            failures++;
            $display("[TB] FAIL commit_value: got %h, required %h", {alarm_hr, alarm_min}, c);
          end
        end
      end
      prev_view   = cur;
      prev_commit = alarm_commit;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int kind;
    rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
    model_reset();
    tick(3);
    checkOutput("reset_state", model_view(), 1'b0);
    rst = 1'b0;
    tick(2);

    // Bouncy mode press gives exactly one RUN -> SET_HR.
    applyStimulus(1'b1, 1'b0, 6, 1'b1);
    checkOutput("bouncy_mode", model_view(), 1'b0);

    // 23 hour incs, 59 minute incs, commit 23:59.
    for (int i = 0; i < 23; i++) applyStimulus(1'b0, 1'b1, 6, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b1, 6, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    checkOutput("commit_23_59", '{eh: 1'b0, em: 1'b0, sv: 6'd0, ah: 5'd23, am: 6'd59}, 1'b0);

    // Both fields wrap: 23 -> 0 and 59 -> 0.
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    applyStimulus(1'b0, 1'b1, 6, 1'b0);
    checkOutput("hour_wrap", '{eh: 1'b1, em: 1'b0, sv: 6'd0, ah: 5'd23, am: 6'd59}, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    applyStimulus(1'b0, 1'b1, 6, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    checkOutput("min_wrap_commit", '{eh: 1'b0, em: 1'b0, sv: 6'd0, ah: 5'd0, am: 6'd0}, 1'b0);

    // Simultaneous mode+inc in SET_HR: mode wins, hour kept.
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 6, 1'b0);
    applyStimulus(1'b1, 1'b1, 6, 1'b0);
    checkOutput("mode_beats_inc", model_view(), 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    checkOutput("hour_kept", '{eh: 1'b0, em: 1'b0, sv: 6'd0, ah: 5'd3, am: 6'd0}, 1'b0);

    // Long hold in SET_MIN from 58.
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    while (m_sm != 58) applyStimulus(1'b0, 1'b1, 6, 1'b0);
    applyStimulus(1'b0, 1'b1, 36, 1'b0);
    checkOutput("hold_inc", model_view(), 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);

    // Random mix of presses, holds, glitches and simultaneous presses.
    for (int i = 0; i < 80; i++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: applyStimulus(1'b1, 1'b0, $urandom_range(5, 9), 1'($urandom_range(0, 1)));
        1, 2: applyStimulus(1'b0, 1'b1, 10 * $urandom_range(0, 3) + 5, 1'b0);
        3: applyGlitch(1'($urandom_range(0, 1)), $urandom_range(1, DEB - 1));
        default: applyStimulus(1'b1, 1'b1, 6, 1'b0);
      endcase
    end
    checkOutput("random_end", model_view(), 1'b0);

    // Reset in SET_MIN at 7:30 with mode held through reset release.
    while (m_mode != 0) applyStimulus(1'b1, 1'b0, 6, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    while (m_sh != 7) applyStimulus(1'b0, 1'b1, 6, 1'b0);
    applyStimulus(1'b1, 1'b0, 6, 1'b0);
    while (m_sm != 30) applyStimulus(1'b0, 1'b1, 6, 1'b0);
    checkOutput("pre_reset_7_30", model_view(), 1'b0);
    rst = 1'b1;
    btn_mode = 1'b1;
    model_reset();
    tick(3);
    checkOutput("mid_edit_reset", model_view(), 1'b0);
    model_mode_press();
    rst = 1'b0;
    tick(2);
    checkOutput("held_btn_no_early_press",
                '{eh: 1'b0, em: 1'b0, sv: 6'd0, ah: 5'd0, am: 6'd0}, 1'b0);
    tick(10);
    btn_mode = 1'b0;
    tick(DEB + 8);
    wait_drain("held_btn_drain");
    checkOutput("held_btn_press", '{eh: 1'b1, em: 1'b0, sv: 6'd0, ah: 5'd0, am: 6'd0}, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
